// File: rtl/drfm_param_loader.sv
// rtl/drfm_param_loader.sv - serial DRFM parameter frame loader (optional PARITY_CHECK_EN adds trailing even parity)
module drfm_param_loader #(
  parameter int CHANNELS  = 4,
  parameter int DELAY_W   = 10,
  parameter int DOPPLER_W = 32,
  parameter int SCALE_W   = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Frame_Start,
  input  logic                          Bit_In,
  input  logic                          Bit_Valid,
  output logic [CHANNELS*DELAY_W-1:0]   Time_Delay,
  output logic [CHANNELS*DOPPLER_W-1:0] Doppler_Shift,
  output logic [CHANNELS*SCALE_W-1:0]   Amplitude_Scale,
  output logic [CHANNELS*4-1:0]         State_o,
  output logic                          Update,
  output logic                          Frame_Error,
  output logic                          Busy
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef PARITY_CHECK_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  // Frame layout, LSB first on the wire
  localparam int OFF_DF  = CH_W;
  localparam int OFF_D   = OFF_DF + 1;
  localparam int OFF_PF  = OFF_D + DELAY_W;
  localparam int OFF_P   = OFF_PF + 1;
  localparam int OFF_SF  = OFF_P + DOPPLER_W;
  localparam int OFF_S   = OFF_SF + 1;
  localparam int DATA_W  = OFF_S + SCALE_W;
  localparam int FRAME_W = DATA_W + PAR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [FRAME_W-1:0]            frame_q;
  logic                          shift_en, commit;
  logic [CHANNELS*DELAY_W-1:0]   delay_q, delay_d;
  logic [CHANNELS*DOPPLER_W-1:0] doppler_q, doppler_d;
  logic [CHANNELS*SCALE_W-1:0]   scale_q, scale_d;
  logic [CHANNELS*4-1:0]         mode_q, mode_d;
  logic                          update_q, update_d;
  logic                          error_q, error_d;

  // Field decode of the assembled frame
  logic [CH_W-1:0]      ch_idx;
  logic                 delay_flag, doppler_flag, scale_flag;
  logic [DELAY_W-1:0]   delay_f;
  logic [DOPPLER_W-1:0] doppler_f;
  logic [SCALE_W-1:0]   scale_f;
  logic                 ch_ok, parity_ok, accept;

  assign ch_idx       = frame_q[CH_W-1:0];
  assign delay_flag   = frame_q[OFF_DF];
  assign delay_f      = frame_q[OFF_D +: DELAY_W];
  assign doppler_flag = frame_q[OFF_PF];
  assign doppler_f    = frame_q[OFF_P +: DOPPLER_W];
  assign scale_flag   = frame_q[OFF_SF];
  assign scale_f      = frame_q[OFF_S +: SCALE_W];
  assign ch_ok        = int'(ch_idx) < CHANNELS;
`ifdef PARITY_CHECK_EN
  assign parity_ok    = ~(^frame_q);
`else
  assign parity_ok    = 1'b1;
`endif
  assign accept       = commit && ch_ok && parity_ok;

  // Next-state logic: Frame_Start always restarts, even dropping a pending commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    commit   = 1'b0;
    if (Frame_Start) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (Bit_Valid) begin
            shift_en = 1'b1;
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              state_d = COMMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          state_d = IDLE;
          commit  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Parameter bank update: only flagged fields of the addressed channel load
  always_comb begin
    delay_d   = delay_q;
    doppler_d = doppler_q;
    scale_d   = scale_q;
    mode_d    = mode_q;
    update_d  = accept;
    error_d   = commit && !accept;
    for (int c = 0; c < CHANNELS; c++) begin
      if (accept && (c == int'(ch_idx))) begin
        if (delay_flag)   delay_d[c*DELAY_W +: DELAY_W]       = delay_f;
        if (doppler_flag) doppler_d[c*DOPPLER_W +: DOPPLER_W] = doppler_f;
        if (scale_flag)   scale_d[c*SCALE_W +: SCALE_W]       = scale_f;
        mode_d[c*4 +: 4] = {doppler_flag, 1'b0, scale_flag, delay_flag};
      end
    end
  end

  // FSM state and bit counter
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame shift register: new bits enter at the top so bit 0 ends up first-received
  always_ff @(posedge Clk) begin
    if (!Reset || Frame_Start) begin
      frame_q <= '0;
    end else if (shift_en) begin
      frame_q <= {Bit_In, frame_q[FRAME_W-1:1]};
    end
  end

  // Output registers, cleared by reset so an in-flight commit is lost
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      delay_q   <= '0;
      doppler_q <= '0;
      scale_q   <= '0;
      mode_q    <= '0;
      update_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      delay_q   <= delay_d;
      doppler_q <= doppler_d;
      scale_q   <= scale_d;
      mode_q    <= mode_d;
      update_q  <= update_d;
      error_q   <= error_d;
    end
  end

  assign Time_Delay      = delay_q;
  assign Doppler_Shift   = doppler_q;
  assign Amplitude_Scale = scale_q;
  assign State_o         = mode_q;
  assign Update          = update_q;
  assign Frame_Error     = error_q;
  assign Busy            = (state_q != IDLE);

endmodule

// File: tb/tb_drfm_param_loader.sv
// tb/tb_drfm_param_loader.sv - directed bench for drfm_param_loader (honours PARITY_CHECK_EN)
module tb_drfm_param_loader;
`ifdef PARITY_CHECK_EN
  localparam int FW = 64;
`else
  localparam int FW = 63;
`endif

  logic Clk = 1'b0, Reset = 1'b0, Frame_Start = 1'b0, Bit_In = 1'b0, Bit_Valid = 1'b0;
  logic [39:0]  td0;  logic [127:0] dp0; logic [63:0] as0; logic [15:0] st0;
  logic up0, fe0, bz0;
  logic [29:0]  td1;  logic [95:0]  dp1; logic [47:0] as1; logic [11:0] st1;
  logic up1, fe1, bz1;

  int pass_cnt = 0, total_cnt = 0;
  int nu0 = 0, ne0 = 0;
  logic busy_c, upd_c, upd_l0, err_l0, upd_l1, err_l1;
  int b_u, b_e;

  always #5 Clk = ~Clk;

  drfm_param_loader dut0 (
    .Clk(Clk), .Reset(Reset), .Frame_Start(Frame_Start), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid),
    .Time_Delay(td0), .Doppler_Shift(dp0), .Amplitude_Scale(as0), .State_o(st0),
    .Update(up0), .Frame_Error(fe0), .Busy(bz0));

  drfm_param_loader #(.CHANNELS(3)) dut1 (
    .Clk(Clk), .Reset(Reset), .Frame_Start(Frame_Start), .Bit_In(Bit_In), .Bit_Valid(Bit_Valid),
    .Time_Delay(td1), .Doppler_Shift(dp1), .Amplitude_Scale(as1), .State_o(st1),
    .Update(up1), .Frame_Error(fe1), .Busy(bz1));

  // Running pulse counts for the default-size instance
  always @(negedge Clk) begin
    if (up0 === 1'b1) nu0 <= nu0 + 1;
    if (fe0 === 1'b1) ne0 <= ne0 + 1;
  end

  function automatic logic [FW-1:0] mk(input int ch, input bit df, input logic [9:0] d,
                                       input bit pf, input logic [31:0] p, input bit sf,
                                       input logic [15:0] s, input bit flip);
    logic [FW-1:0] f;
    logic [31:0] chv;
    chv = ch;
    f = '0;
    f[1:0] = chv[1:0];
    f[2] = df;
    f[12:3] = d;
    f[13] = pf;
    f[45:14] = p;
    f[46] = sf;
    f[62:47] = s;
`ifdef PARITY_CHECK_EN
    f[63] = (^f[62:0]) ^ flip;
`else
    if (flip) f[0] = ~f[0];
`endif
    return f;
  endfunction

  task automatic send_bits(input logic [FW-1:0] f, input int n);
    @(negedge Clk); Frame_Start = 1'b1; Bit_Valid = 1'b0;
    @(negedge Clk); Frame_Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      Bit_In = f[i]; Bit_Valid = 1'b1;
      @(negedge Clk);
    end
    Bit_Valid = 1'b0; Bit_In = 1'b0;
  endtask

  task automatic observe();
    busy_c = bz0; upd_c = up0;
    @(negedge Clk);
    upd_l0 = up0; err_l0 = fe0; upd_l1 = up1; err_l1 = fe1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_td", td0, 0); chk("reset_dp", dp0, 0); chk("reset_as", as0, 0);
    chk("reset_st", st0, 0); chk("reset_upd", up0, 0); chk("reset_err", fe0, 0);
    chk("reset_busy", bz0, 0);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_delay_load();
    b_u = nu0;
    send_bits(mk(2, 1, 10'h155, 0, 0, 0, 0, 0), FW);
    observe();
    chk("delay_commit_busy", busy_c, 1);
    chk("delay_commit_upd_early", upd_c, 0);
    chk("delay_upd_latency", upd_l0, 1);
    chk("delay_upd_count", nu0 - b_u, 1);
    chk("delay_td", td0, 40'h0015500000);
    chk("delay_st", st0, 16'h0100);
    chk("delay_dp", dp0, 0);
  endtask

  task automatic test_all_fields();
    send_bits(mk(1, 1, 10'h3FF, 1, 32'hDEADBEEF, 1, 16'h8000, 0), FW);
    observe();
    chk("all_upd", upd_l0, 1);
    chk("all_td", td0, 40'h00155FFC00);
    chk("all_dp", dp0, 128'h00000000_00000000_DEADBEEF_00000000);
    chk("all_as", as0, 64'h0000_0000_8000_0000);
    chk("all_st", st0, 16'h01B0);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity_error();
    b_u = nu0;
    send_bits(mk(2, 1, 10'h155, 0, 0, 0, 0, 1), FW);
    observe();
    chk("parity_err", err_l0, 1);
    chk("parity_no_upd", nu0 - b_u, 0);
    chk("parity_td", td0, 40'h00155FFC00);
    chk("parity_st", st0, 16'h01B0);
  endtask
`endif

  task automatic test_partial_flags();
    send_bits(mk(1, 0, 10'h001, 0, 32'h12345678, 1, 16'h1234, 0), FW);
    observe();
    chk("partial_upd", upd_l0, 1);
    chk("partial_td_hold", td0, 40'h00155FFC00);
    chk("partial_dp_hold", dp0, 128'h00000000_00000000_DEADBEEF_00000000);
    chk("partial_as", as0, 64'h0000_0000_1234_0000);
    chk("partial_st", st0, 16'h0120);
  endtask

  task automatic test_bad_channel();
    send_bits(mk(3, 1, 10'h2AA, 0, 0, 0, 0, 0), FW);
    observe();
    chk("ch3_dut4_upd", upd_l0, 1);
    chk("ch3_dut4_td", td0, 40'hAA955FFC00);
    chk("ch3_dut4_st", st0, 16'h1120);
    chk("ch3_dut3_err", err_l1, 1);
    chk("ch3_dut3_no_upd", upd_l1, 0);
    chk("ch3_dut3_td", td1, 30'h155FFC00);
    chk("ch3_dut3_st", st1, 12'h120);
    chk("ch3_dut3_as", as1, 48'h0000_1234_0000);
  endtask

  task automatic test_wait_frame();
    send_bits(mk(2, 0, 10'h3AB, 0, 0, 0, 0, 0), FW);
    observe();
    chk("wait_upd", upd_l0, 1);
    chk("wait_st", st0, 16'h1020);
    chk("wait_td_hold", td0, 40'hAA955FFC00);
  endtask

  task automatic test_restart();
    b_u = nu0; b_e = ne0;
    send_bits(mk(0, 1, 10'h0AB, 0, 0, 0, 0, 0), 20);
    send_bits(mk(0, 1, 10'h0CD, 0, 0, 0, 0, 0), FW);
    observe();
    chk("restart_upd_count", nu0 - b_u, 1);
    chk("restart_err_count", ne0 - b_e, 0);
    chk("restart_td", td0, 40'hAA955FFCCD);
    chk("restart_st", st0, 16'h1021);
  endtask

  task automatic test_short_frame();
    b_u = nu0; b_e = ne0;
    send_bits(mk(0, 1, 10'h111, 0, 0, 0, 0, 0), FW - 1);
    repeat (4) @(negedge Clk);
    chk("short_busy", bz0, 1);
    chk("short_no_upd", nu0 - b_u, 0);
    chk("short_no_err", ne0 - b_e, 0);
    chk("short_td_hold", td0, 40'hAA955FFCCD);
  endtask

  task automatic test_reset_commit();
    b_u = nu0;
    send_bits(mk(3, 1, 10'h3FF, 0, 0, 0, 0, 0), FW);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rstc_td", td0, 0); chk("rstc_dp", dp0, 0); chk("rstc_as", as0, 0);
    chk("rstc_st", st0, 0); chk("rstc_upd", up0, 0); chk("rstc_busy", bz0, 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rstc_no_upd", nu0 - b_u, 0);
    send_bits(mk(0, 1, 10'h002, 0, 0, 0, 0, 0), FW);
    observe();
    chk("post_rst_upd", upd_l0, 1);
    chk("post_rst_td", td0, 40'h0000000002);
    chk("post_rst_st", st0, 16'h0001);
  endtask

  initial begin
    test_reset();
    test_delay_load();
    test_all_fields();
`ifdef PARITY_CHECK_EN
    test_parity_error();
`endif
    test_partial_flags();
    test_bad_channel();
    test_wait_frame();
    test_restart();
    test_short_frame();
    test_reset_commit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
